// File: rtl/uart_loader_pkg.sv
// Shared types and helpers for the UART boot-frame memory loader.
// The checksum helper is width-generic up to 32 bits so other UART-side blocks can reuse it.
package uart_loader_pkg;

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} loader_state_t;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

  function automatic logic [31:0] csum_add(input logic [31:0] acc,
                                           input logic [31:0] b,
                                           input int unsigned width);
    logic [31:0] sum;
    sum = acc + b;
    return (width >= 32) ? sum : (sum & ((32'd1 << width) - 32'd1));
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Loadable down-counter used as an inter-byte watchdog.
// It reports expiry while enabled and the count has drained to zero; load wins over clear.
module loader_timeout #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = enable && (count == '0);

endmodule

// File: rtl/uart_mem_loader.sv
// Parses MAGIC/LEN/payload/checksum boot frames from uart_rx and writes the payload from address 0.
// The CPU stays held until a frame with a good checksum has been fully written.
module uart_mem_loader
  import uart_loader_pkg::*;
#(
  parameter int                    WORD_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 3,
  parameter logic [WORD_WIDTH-1:0] MAGIC      = WORD_WIDTH'(DEFAULT_MAGIC),
  parameter int                    TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [WORD_WIDTH-1:0] rx_data,
  input  logic                  rx_err,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int TMR_W = $clog2(TIMEOUT);

  loader_state_t         state, state_next;
  logic [ADDR_WIDTH:0]   idx, idx_inc, len_q;
  logic [WORD_WIDTH-1:0] checksum, sum_next;
  logic                  frame_active, len_ok;
  logic                  timer_load, timer_expired;

  assign frame_active = (state == LEN) || (state == DATA) || (state == CSUM);
  assign len_ok       = (rx_data != '0) && (int'(rx_data) <= DEPTH);
  assign idx_inc      = idx + (ADDR_WIDTH+1)'(1);
  assign sum_next     = WORD_WIDTH'(csum_add(32'(checksum), 32'(rx_data), WORD_WIDTH));

  // Loaded with TIMEOUT-1 so the TIMEOUT-th silent cycle is the one that aborts.
  loader_timeout #(.WIDTH(TMR_W)) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (!frame_active),
    .load       (timer_load),
    .load_value (TMR_W'(TIMEOUT - 1)),
    .enable     (frame_active),
    .expired    (timer_expired)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    if (frame_active && rx_err) begin
      state_next = ERR;
    end else if (rx_valid) begin
      case (state)
        IDLE, DONE, ERR: if (rx_data == MAGIC) begin
          state_next = LEN;
          timer_load = 1'b1;
        end
        LEN: begin
          state_next = len_ok ? DATA : ERR;
          timer_load = len_ok;
        end
        DATA: begin
          timer_load = 1'b1;
          if (idx_inc == len_q) state_next = CSUM;
        end
        CSUM:    state_next = (rx_data == checksum) ? DONE : ERR;
        default: state_next = IDLE;
      endcase
    end else if (timer_expired) begin
      state_next = ERR;
    end
  end

  // Status outputs are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      len_q     <= '0;
      checksum  <= '0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_next;
      busy      <= (state_next == LEN) || (state_next == DATA) || (state_next == CSUM);
      done      <= (state_next == DONE);
      error     <= (state_next == ERR);
      cpu_hold  <= (state_next != DONE);
      mem_write <= 1'b0;
      if (rx_valid && !rx_err) begin
        case (state)
          LEN: if (len_ok) begin
            len_q    <= rx_data[ADDR_WIDTH:0];
            idx      <= '0;
            checksum <= '0;
            mem_addr <= '0;
          end
          DATA: begin
            mem_write <= 1'b1;
            mem_addr  <= idx[ADDR_WIDTH-1:0];
            mem_wdata <= rx_data;
            idx       <= idx_inc;
            checksum  <= sum_next;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader (DEPTH=8, TIMEOUT=16) with hand-computed expectations.
// Outputs are sampled on the falling edge; writes are logged by a falling-edge monitor.
module tb_uart_mem_loader;

  localparam int WW = 8;
  localparam int AW = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [WW-1:0] rx_data = '0;
  logic          rx_err = 1'b0;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic          cpu_hold, busy, done, error;

  uart_mem_loader #(
    .WORD_WIDTH (WW),
    .ADDR_WIDTH (AW),
    .MAGIC      (8'hA5),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_err    (rx_err),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] log_addr[$];
  logic [WW-1:0] log_data[$];

  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic b, input logic d,
                              input logic e, input logic h);
    check({tag, ".busy"},     32'(busy),     32'(b));
    check({tag, ".done"},     32'(done),     32'(d));
    check({tag, ".error"},    32'(error),    32'(e));
    check({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(h));
  endtask

  task automatic check_write(input string tag, input logic [AW-1:0] a, input logic [WW-1:0] d);
    check({tag, ".mem_write"}, 32'(mem_write), 32'd1);
    check({tag, ".mem_addr"},  32'(mem_addr),  32'(a));
    check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(d));
  endtask

  // Called at a falling edge; holds the strobe for exactly one rising edge.
  task automatic strobe(input logic [WW-1:0] b, input logic err = 1'b0);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_err   = err;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    check_status("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset.mem_write", 32'(mem_write), 32'd0);
    check("reset.mem_addr",  32'(mem_addr),  32'd0);
    check("reset.mem_wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Noise in IDLE
    clear_log();
    strobe(8'h00); strobe(8'hFF); strobe(8'h5A);
    idle(2);
    check_status("noise", 1'b0, 1'b0, 1'b0, 1'b1);
    check("noise.writes", 32'(log_addr.size()), 32'd0);

    // Good frame, back-to-back strobes
    clear_log();
    strobe(8'hA5);
    check("good.busy_after_magic", 32'(busy), 32'd1);
    strobe(8'h03);
    strobe(8'h11); check_write("good.w0", 3'd0, 8'h11);
    strobe(8'h22); check_write("good.w1", 3'd1, 8'h22);
    strobe(8'h33); check_write("good.w2", 3'd2, 8'h33);
    strobe(8'h66);
    check("good.no_write_on_csum", 32'(mem_write), 32'd0);
    check_status("good", 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("good.writes", 32'(log_addr.size()), 32'd3);

    // Bad checksum, then recovery
    clear_log();
    strobe(8'hA5); strobe(8'h02); strobe(8'h10); strobe(8'h20); strobe(8'h31);
    idle(1);
    check_status("badsum", 1'b0, 1'b0, 1'b1, 1'b1);
    check("badsum.writes", 32'(log_addr.size()), 32'd2);
    check("badsum.a0", 32'(log_addr[0]), 32'd0);
    check("badsum.d0", 32'(log_data[0]), 32'h10);
    check("badsum.a1", 32'(log_addr[1]), 32'd1);
    check("badsum.d1", 32'(log_data[1]), 32'h20);
    strobe(8'hA5); strobe(8'h01); strobe(8'h7F); strobe(8'h7F);
    check_status("recover", 1'b0, 1'b1, 1'b0, 1'b0);

    // Length bounds
    clear_log();
    strobe(8'hA5); strobe(8'h00);
    check_status("len0", 1'b0, 1'b0, 1'b1, 1'b1);
    strobe(8'hA5); strobe(8'h09);
    check_status("len9", 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    check("len_bad.writes", 32'(log_addr.size()), 32'd0);
    strobe(8'hA5); strobe(8'h08);
    for (int i = 1; i <= 8; i++) strobe(8'(i));
    strobe(8'h24);
    idle(1);
    check_status("len8", 1'b0, 1'b1, 1'b0, 1'b0);
    check("len8.writes", 32'(log_addr.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("len8.a%0d", i), 32'(log_addr[i]), 32'(i));
      check($sformatf("len8.d%0d", i), 32'(log_data[i]), 32'(i + 1));
    end

    // Reload after DONE with MAGIC as payload
    clear_log();
    strobe(8'hA5);
    check_status("reload.start", 1'b1, 1'b0, 1'b0, 1'b1);
    strobe(8'h01);
    strobe(8'hA5); check_write("reload.w0", 3'd0, 8'hA5);
    strobe(8'hA5);
    check_status("reload.end", 1'b0, 1'b1, 1'b0, 1'b0);

    // Inter-byte timeout
    clear_log();
    strobe(8'hA5); strobe(8'h02); strobe(8'h44);
    idle(TO - 1);
    check_status("timeout.before", 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    check_status("timeout.after", 1'b0, 1'b0, 1'b1, 1'b1);
    check("timeout.writes", 32'(log_addr.size()), 32'd1);

    // rx_err on the second data byte
    clear_log();
    strobe(8'hA5); strobe(8'h03); strobe(8'h11); strobe(8'h22, 1'b1);
    check("rxerr.mem_write", 32'(mem_write), 32'd0);
    check_status("rxerr", 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    check("rxerr.writes", 32'(log_addr.size()), 32'd1);
    check("rxerr.d0", 32'(log_data[0]), 32'h11);

    // Asynchronous reset mid-DATA
    strobe(8'hA5); strobe(8'h03); strobe(8'h11);
    check("areset.pre_write", 32'(mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_status("areset", 1'b0, 1'b0, 1'b0, 1'b1);
    check("areset.mem_write", 32'(mem_write), 32'd0);
    check("areset.mem_addr",  32'(mem_addr),  32'd0);
    check("areset.mem_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check_status("post_reset", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Write-side initiator for the processor's program/data memory.
- Takes bytes already deframed by the UART receiver, parses a boot frame (magic, length, payload, checksum) and drives the memory write port sequentially from address 0.
- Holds the CPU in hold while loading; releases it only after a frame whose checksum is good.
- Sits between uart_rx and the memory write port. Top level gates mem_wdata onto the memory's bidirectional operand bus only while mem_write=1.

Parameters:
- WORD_WIDTH, 8, data/byte width; also checksum width.
- ADDR_WIDTH, 3, memory address width; DEPTH = 2**ADDR_WIDTH words.
- MAGIC, 8'hA5, frame start word (WORD_WIDTH bits).
- TIMEOUT, 1024, idle cycles allowed between bytes inside a frame; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- rx_data  in  WORD_WIDTH  received byte.
- rx_err  in  1  framing/parity error strobe from the receiver, same cycle as a rx_valid or standalone.
- mem_write  out  1  memory write enable, one-cycle pulse.
- mem_addr  out  ADDR_WIDTH  memory write address.
- mem_wdata  out  WORD_WIDTH  memory write data.
- cpu_hold  out  1  1 = CPU stalled, fetch disabled.
- busy  out  1  frame in progress (LEN, DATA or CSUM).
- done  out  1  level; last frame loaded with good checksum.
- error  out  1  level; last frame aborted.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE. cpu_hold=1; mem_write, busy, done, error = 0; mem_addr=0; mem_wdata=0; count, checksum and timer cleared.
  - Reset asserted mid-frame abandons the frame immediately. Memory contents already written are not touched.
- All outputs are registered. Inputs are sampled on rising clk only when rx_valid=1, except rx_err, which is sampled every cycle.
- States:
  - IDLE: rx_valid with rx_data==MAGIC -> LEN. Any other byte is ignored.
  - LEN: the byte is N. N==0 or N>DEPTH -> ERR; otherwise store N, clear checksum, mem_addr=0, -> DATA.
  - DATA: each byte is written as mem_write=1, mem_wdata=byte, mem_addr=current index, registered one cycle after rx_valid. The index then increments; checksum += byte modulo 2**WORD_WIDTH. After the N-th byte -> CSUM.
  - CSUM: byte == checksum -> DONE; otherwise -> ERR.
  - DONE: done=1, cpu_hold=0, busy=0. A MAGIC byte -> LEN, with done=0 and cpu_hold=1 on the next edge.
  - ERR: error=1, cpu_hold=1. A MAGIC byte -> LEN and clears error.
- busy=1 exactly while in LEN, DATA or CSUM.
- rx_err in LEN, DATA or CSUM -> ERR. The accompanying byte is discarded; no write occurs for it. rx_err in IDLE, DONE or ERR is ignored.
- Timeout:
  - Timer resets on every rx_valid. It counts cycles without rx_valid in LEN, DATA or CSUM.
  - On reaching TIMEOUT -> ERR.
  - Timer is held at 0 outside those states.
- Partial writes are not rolled back on error. The CPU stays held, so they are harmless.
- Address wrap cannot occur because N <= DEPTH. The index register must be ADDR_WIDTH+1 bits to count to DEPTH.
- mem_write is never asserted outside DATA. Back-to-back rx_valid on consecutive cycles must be supported, giving consecutive write pulses.
- MAGIC received inside LEN or DATA is treated as ordinary data, not a restart.

Decomposition:
- Package uart_loader_pkg:
  - state enum loader_state_t {IDLE, LEN, DATA, CSUM, DONE, ERR};
  - default MAGIC constant;
  - checksum helper function, add modulo 2**WORD_WIDTH.
- One sub-module: loader_timeout. It is a loadable down-counter with clear and enable inputs and an expired output, reusable by other UART-side blocks.
- The FSM, index, and checksum remain in uart_mem_loader.

Test Plan:
- Good frame: A5,03,11,22,33,66 on consecutive-cycle strobes -> writes (0,11),(1,22),(2,33), one cycle after each strobe; then done=1, cpu_hold=0, error=0.
- Bad checksum: A5,02,10,20,31 -> two writes, then error=1, done=0, cpu_hold=1. A following good frame A5,01,7F,7F -> done=1, error=0.
- Length bounds with DEPTH=8: A5,00 -> ERR with no write; A5,09 -> ERR with no write; A5,08 plus 8 bytes plus correct sum -> 8 writes at addresses 0..7, done=1.
- Timeout with TIMEOUT=16: A5,02,44 then silence -> error=1 exactly 16 cycles after the 44 strobe; busy=0 afterwards.
- Abort conditions: rx_err together with the second data byte -> no write for that byte, ERR. Separately, rst_n low mid-DATA -> all outputs at reset values immediately, asynchronously.
- Noise and reload: bytes 00,FF,5A in IDLE -> ignored, no state change. After DONE, A5,01,A5,A5 -> cpu_hold rises next edge, write (0,A5) (MAGIC accepted as data), done=1 again.
